// File: rtl/mac_pkg.sv
// Shared constants, pipeline tag type and the overflow-aware accumulate
// helper for the multiply-accumulate unit.
package mac_pkg;

   localparam int WIDTH_A_DEF     = 8;
   localparam int WIDTH_F_DEF     = 20;
   localparam int PIPE_STAGES_MAX = 2;
   localparam int ACC_MAX         = 64;

   typedef struct packed {
      logic valid;
      logic clear;
   } tag_t;

   typedef struct packed {
      logic [ACC_MAX-1:0] f_next;
      logic               ovf;
   } sat_res_t;

   // f and p must already fit in 'width' bits; the carry out of bit width-1
   // is the overflow, and saturation replaces the wrapped sum with all ones.
   function automatic sat_res_t sat_add(input logic [ACC_MAX-1:0] f,
                                        input logic [ACC_MAX-1:0] p,
                                        input int unsigned        width,
                                        input logic               saturate);
      logic [ACC_MAX:0]   sum;
      logic [ACC_MAX-1:0] mask;
      sat_res_t           res;
      sum        = {1'b0, f} + {1'b0, p};
      mask       = {ACC_MAX{1'b1}} >> (ACC_MAX - width);
      res.ovf    = |(sum >> width);
      res.f_next = (res.ovf && saturate) ? mask : (sum[ACC_MAX-1:0] & mask);
      return res;
   endfunction

endpackage

// File: rtl/mac_tag_pipe.sv
// Delay line for the valid/clear tags (STAGES+1 deep, stage 0 sits beside the
// operand registers) and for the product (STAGES deep, after the multiplier).
module mac_tag_pipe
   import mac_pkg::*;
#(
   parameter int STAGES = 0,
   parameter int PW     = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  tag_t          tag_in,
   input  logic [PW-1:0] p_in,
   output tag_t          tag_out,
   output logic [PW-1:0] p_out
);

   logic [STAGES:0] vld_pipe;
   logic [STAGES:0] clr_pipe;

   always_ff @(posedge clk) begin
      if (reset) begin
         vld_pipe <= '0;
         clr_pipe <= '0;
      end else begin
         vld_pipe[0] <= tag_in.valid;
         clr_pipe[0] <= tag_in.clear;
         for (int i = 1; i <= STAGES; i++) begin
            vld_pipe[i] <= vld_pipe[i-1];
            clr_pipe[i] <= clr_pipe[i-1];
         end
      end
   end

   assign tag_out.valid = vld_pipe[STAGES];
   assign tag_out.clear = clr_pipe[STAGES];

   generate
      if (STAGES == 0) begin : g_nopipe
         assign p_out = p_in;
      end else begin : g_pipe
         logic [STAGES-1:0][PW-1:0] p_q;
         always_ff @(posedge clk) begin
            if (reset) begin
               p_q <= '0;
            end else begin
               p_q[0] <= p_in;
               for (int i = 1; i < STAGES; i++) p_q[i] <= p_q[i-1];
            end
         end
         assign p_out = p_q[STAGES-1];
      end
   endgenerate

endmodule

// File: rtl/mac_accum.sv
// Multiply-accumulate: registered operands, unsigned multiply, optional
// product pipeline, and a single-cycle accumulator with wrap/saturate overflow.
module mac_accum
   import mac_pkg::*;
#(
   parameter int WIDTH_A     = WIDTH_A_DEF,
   parameter int WIDTH_F     = WIDTH_F_DEF,
   parameter int PIPE_STAGES = 0,
   parameter int SATURATE    = 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [WIDTH_A-1:0] a,
   input  logic [WIDTH_A-1:0] b,
   input  logic               valid_in,
   input  logic               clear_acc,
   output logic [WIDTH_F-1:0] f,
   output logic               valid_out,
   output logic               overflow
);

   localparam int PW = 2 * WIDTH_A;

   generate
      if (WIDTH_F < PW) begin : g_bad_width
         $error("mac_accum: WIDTH_F must be >= 2*WIDTH_A");
      end
      if (WIDTH_F > ACC_MAX) begin : g_bad_acc
         $error("mac_accum: WIDTH_F exceeds sat_add range");
      end
      if (PIPE_STAGES < 0 || PIPE_STAGES > PIPE_STAGES_MAX) begin : g_bad_pipe
         $error("mac_accum: PIPE_STAGES out of range");
      end
   endgenerate

   logic [WIDTH_A-1:0] a_q, b_q;
   logic [PW-1:0]      prod, p_fin;
   tag_t               tag_in, tag_fin;
   sat_res_t           sum_res;
   logic               unused_sum;

   // Operands hold on idle cycles; their tag enters the pipe every cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         a_q <= '0;
         b_q <= '0;
      end else if (valid_in) begin
         a_q <= a;
         b_q <= b;
      end
   end

   assign prod         = PW'(a_q) * PW'(b_q);
   assign tag_in.valid = valid_in;
   assign tag_in.clear = valid_in & clear_acc;

   mac_tag_pipe #(
      .STAGES (PIPE_STAGES),
      .PW     (PW)
   ) u_tag_pipe (
      .clk     (clk),
      .reset   (reset),
      .tag_in  (tag_in),
      .p_in    (prod),
      .tag_out (tag_fin),
      .p_out   (p_fin)
   );

   assign sum_res    = sat_add(ACC_MAX'(f), ACC_MAX'(p_fin), WIDTH_F, SATURATE != 0);
   assign unused_sum = ^sum_res.f_next;

   // Feedback through f closes in one cycle regardless of pipeline depth.
   always_ff @(posedge clk) begin
      if (reset) begin
         f         <= '0;
         valid_out <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         valid_out <= tag_fin.valid;
         if (tag_fin.valid) begin
            if (tag_fin.clear) begin
               f        <= WIDTH_F'(p_fin);
               overflow <= 1'b0;
            end else begin
               f <= sum_res.f_next[WIDTH_F-1:0];
               if (sum_res.ovf) overflow <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_mac_accum.sv
// Bench for mac_accum: three instances (saturate, wrap, 2-stage pipe) share
// one stimulus stream; directed scenarios plus a randomized run vs a model.
module tb_mac_accum;

   localparam int NC   = 3;
   localparam int MAXF = (1 << 20) - 1;

   logic       clk = 1'b0, reset = 1'b0, valid_in = 1'b0, clear_acc = 1'b0;
   logic [7:0] a = '0, b = '0;
   logic [19:0] f_o [NC];
   logic        vo  [NC];
   logic        ov  [NC];

   int total = 0, bad = 0, en = 0;

   // Reference: each accepted sample's result is posted at its arrival edge.
   bit     s_set [NC][8192];
   bit     s_vld [NC][8192];
   bit     s_ovf [NC][8192];
   int     s_f   [NC][8192];
   longint m_f   [NC];
   bit     m_ovf [NC];

   mac_accum #(.SATURATE(1)) dut0 (.clk(clk), .reset(reset), .a(a), .b(b),
      .valid_in(valid_in), .clear_acc(clear_acc), .f(f_o[0]), .valid_out(vo[0]), .overflow(ov[0]));
   mac_accum #(.SATURATE(0)) dut1 (.clk(clk), .reset(reset), .a(a), .b(b),
      .valid_in(valid_in), .clear_acc(clear_acc), .f(f_o[1]), .valid_out(vo[1]), .overflow(ov[1]));
   mac_accum #(.PIPE_STAGES(2)) dut2 (.clk(clk), .reset(reset), .a(a), .b(b),
      .valid_in(valid_in), .clear_acc(clear_acc), .f(f_o[2]), .valid_out(vo[2]), .overflow(ov[2]));

   always #5 clk = ~clk;

   function automatic int pst(input int k);
      return (k == 2) ? 2 : 0;
   endfunction

   function automatic bit sat(input int k);
      return k != 1;
   endfunction

   function automatic int exp_f(input int k, input int n);
      for (int i = n; i >= 0; i--) if (s_set[k][i]) return s_f[k][i];
      return 0;
   endfunction

   function automatic bit exp_o(input int k, input int n);
      for (int i = n; i >= 0; i--) if (s_set[k][i]) return s_ovf[k][i];
      return 1'b0;
   endfunction

   task automatic model_step(input int ai, bi, input bit v, c, r);
      for (int k = 0; k < NC; k++) begin
         int n;
         n = en + 1 + pst(k);
         if (r) begin
            for (int i = en; i < en + 4; i++) begin s_set[k][i] = 0; s_vld[k][i] = 0; end
            s_set[k][en] = 1; s_f[k][en] = 0; s_ovf[k][en] = 0;
            m_f[k] = 0; m_ovf[k] = 0;
         end else if (v) begin
            if (c) begin
               m_f[k] = ai * bi; m_ovf[k] = 0;
            end else begin
               m_f[k] = m_f[k] + ai * bi;
               if (m_f[k] > MAXF) begin
                  m_ovf[k] = 1;
                  m_f[k]   = sat(k) ? MAXF : m_f[k] - (MAXF + 1);
               end
            end
            s_set[k][n] = 1; s_vld[k][n] = 1; s_f[k][n] = int'(m_f[k]); s_ovf[k][n] = m_ovf[k];
         end
      end
   endtask

   task automatic tick(input int ai, bi, input bit v, c, r);
      a = 8'(ai); b = 8'(bi); valid_in = v; clear_acc = c; reset = r;
      @(posedge clk);
      en++;
      model_step(ai, bi, v, c, r);
      #1;
   endtask

   task automatic test_reset;
      tick(0, 0, 0, 0, 1);
      for (int k = 0; k < NC; k++) begin
         total++; if (f_o[k] !== 20'd0) begin bad++; $display("FAIL reset_f[%0d]: got %0d want 0", k, f_o[k]); end
         total++; if (vo[k] !== 1'b0) begin bad++; $display("FAIL reset_vld[%0d]: got %0b want 0", k, vo[k]); end
         total++; if (ov[k] !== 1'b0) begin bad++; $display("FAIL reset_ovf[%0d]: got %0b want 0", k, ov[k]); end
      end
   endtask

   task automatic test_basic;
      int nf [5] = '{441, 1737, 1737, 1737, 1737};
      bit nv [5] = '{1, 1, 0, 0, 0};
      int pf [5] = '{0, 0, 441, 1737, 1737};
      bit pv [5] = '{0, 0, 1, 1, 0};
      tick(0, 0, 0, 0, 0);
      tick(21, 21, 1, 0, 0);
      for (int k = 0; k < NC; k++) begin
         total++; if (vo[k] !== 1'b0) begin bad++; $display("FAIL basic_early_vld[%0d]: got %0b want 0", k, vo[k]); end
      end
      for (int s = 0; s < 5; s++) begin
         if (s == 0) tick(36, 36, 1, 0, 0); else tick(0, 0, 0, 0, 0);
         for (int k = 0; k < NC; k++) begin
            total++;
            if (vo[k] !== (pst(k) == 2 ? pv[s] : nv[s])) begin
               bad++; $display("FAIL basic_vld[%0d] step %0d: got %0b", k, s, vo[k]);
            end
            total++;
            if (f_o[k] !== 20'(pst(k) == 2 ? pf[s] : nf[s])) begin
               bad++; $display("FAIL basic_f[%0d] step %0d: got %0d want %0d", k, s, f_o[k], pst(k) == 2 ? pf[s] : nf[s]);
            end
         end
      end
   endtask

   task automatic test_gap_max;
      int ops [4] = '{0, 255, 64, 0};
      bit ovl [4] = '{1, 1, 1, 0};
      int ef  [4] = '{5833, 5833, 70858, 74954};
      tick(0, 0, 0, 0, 0);
      tick(0, 0, 0, 0, 0);
      tick(64, 64, 1, 0, 0);
      for (int i = 0; i < 4; i++) begin
         tick(ops[i], ops[i], ovl[i], 0, 0);
         for (int k = 0; k < 2; k++) begin
            total++; if (vo[k] !== 1'b1) begin bad++; $display("FAIL gap_vld[%0d] #%0d: got %0b want 1", k, i, vo[k]); end
            total++; if (f_o[k] !== 20'(ef[i])) begin bad++; $display("FAIL gap_f[%0d] #%0d: got %0d want %0d", k, i, f_o[k], ef[i]); end
         end
      end
      total++; if (ov[0] !== 1'b0) begin bad++; $display("FAIL gap_ovf: got %0b want 0", ov[0]); end
      repeat (3) tick(0, 0, 0, 0, 0);
      total++; if (f_o[2] !== 20'd74954 || vo[2] !== 1'b0) begin
         bad++; $display("FAIL gap_pipe: got f=%0d vld=%0b want f=74954 vld=0", f_o[2], vo[2]);
      end
   endtask

   task automatic test_saturate;
      for (int i = 1; i <= 19; i++) begin
         if (i <= 18) tick(255, 255, 1, i == 1, 0); else tick(0, 0, 0, 0, 0);
         if (i == 17) begin
            for (int k = 0; k < 2; k++) begin
               total++; if (f_o[k] !== 20'd1040400 || ov[k] !== 1'b0 || vo[k] !== 1'b1) begin
                  bad++; $display("FAIL sat16[%0d]: got f=%0d ovf=%0b vld=%0b want 1040400/0/1", k, f_o[k], ov[k], vo[k]);
               end
            end
         end
         if (i == 18) begin
            total++; if (f_o[0] !== 20'd1048575 || ov[0] !== 1'b1) begin
               bad++; $display("FAIL sat17: got f=%0d ovf=%0b want 1048575/1", f_o[0], ov[0]);
            end
            total++; if (f_o[1] !== 20'd56849 || ov[1] !== 1'b1) begin
               bad++; $display("FAIL wrap17: got f=%0d ovf=%0b want 56849/1", f_o[1], ov[1]);
            end
         end
         if (i == 19) begin
            total++; if (f_o[0] !== 20'd1048575 || ov[0] !== 1'b1) begin
               bad++; $display("FAIL sat18: got f=%0d ovf=%0b want 1048575/1", f_o[0], ov[0]);
            end
            total++; if (f_o[1] !== 20'd121874 || ov[1] !== 1'b1) begin
               bad++; $display("FAIL wrap18: got f=%0d ovf=%0b want 121874/1", f_o[1], ov[1]);
            end
         end
      end
      repeat (3) tick(0, 0, 0, 0, 0);
      total++; if (f_o[2] !== 20'd1048575 || ov[2] !== 1'b1) begin
         bad++; $display("FAIL sat_pipe: got f=%0d ovf=%0b want 1048575/1", f_o[2], ov[2]);
      end
   endtask

   task automatic test_reset_mid;
      tick(10, 10, 1, 0, 0);
      tick(20, 20, 1, 0, 0);
      tick(30, 30, 1, 0, 1);
      for (int k = 0; k < NC; k++) begin
         total++; if (f_o[k] !== 20'd0 || vo[k] !== 1'b0 || ov[k] !== 1'b0) begin
            bad++; $display("FAIL midreset[%0d]: got f=%0d vld=%0b ovf=%0b want 0/0/0", k, f_o[k], vo[k], ov[k]);
         end
      end
      for (int s = 0; s < 4; s++) begin
         tick(0, 0, 0, 0, 0);
         for (int k = 0; k < NC; k++) begin
            total++; if (vo[k] !== 1'b0 || f_o[k] !== 20'd0) begin
               bad++; $display("FAIL midreset_after[%0d] step %0d: got f=%0d vld=%0b want 0/0", k, s, f_o[k], vo[k]);
            end
         end
      end
   endtask

   task automatic test_clear;
      repeat (17) tick(255, 255, 1, 0, 0);
      tick(21, 21, 1, 1, 0);
      total++; if (ov[0] !== 1'b1) begin bad++; $display("FAIL clr_preovf: got %0b want 1", ov[0]); end
      tick(2, 2, 1, 1, 0);
      tick(3, 3, 1, 0, 0);
      for (int k = 0; k < 2; k++) begin
         total++; if (f_o[k] !== 20'd4 || ov[k] !== 1'b0 || vo[k] !== 1'b1) begin
            bad++; $display("FAIL clr_f4[%0d]: got f=%0d ovf=%0b vld=%0b want 4/0/1", k, f_o[k], ov[k], vo[k]);
         end
      end
      tick(0, 0, 0, 1, 0);
      total++; if (f_o[0] !== 20'd13 || vo[0] !== 1'b1) begin
         bad++; $display("FAIL clr_f13: got f=%0d vld=%0b want 13/1", f_o[0], vo[0]);
      end
      tick(0, 0, 0, 1, 0);
      total++; if (f_o[0] !== 20'd13 || vo[0] !== 1'b0) begin
         bad++; $display("FAIL clr_idle: got f=%0d vld=%0b want 13/0", f_o[0], vo[0]);
      end
      tick(1, 1, 1, 0, 0);
      tick(0, 0, 0, 0, 0);
      total++; if (f_o[0] !== 20'd14 || vo[0] !== 1'b1) begin
         bad++; $display("FAIL clr_ignored: got f=%0d vld=%0b want 14/1", f_o[0], vo[0]);
      end
      repeat (3) tick(0, 0, 0, 0, 0);
      total++; if (f_o[2] !== 20'd14 || ov[2] !== 1'b0) begin
         bad++; $display("FAIL clr_pipe: got f=%0d ovf=%0b want 14/0", f_o[2], ov[2]);
      end
   endtask

   task automatic test_random;
      tick(0, 0, 0, 0, 1);
      for (int s = 0; s < 500; s++) begin
         int  ai, bi;
         bit  v, c, r;
         ai = ($urandom_range(0, 9) < 3) ? int'($urandom_range(200, 255)) : int'($urandom_range(0, 255));
         bi = ($urandom_range(0, 9) < 3) ? int'($urandom_range(200, 255)) : int'($urandom_range(0, 255));
         v  = $urandom_range(0, 3) != 0;
         c  = $urandom_range(0, 9) == 0;
         r  = $urandom_range(0, 99) < 2;
         tick(ai, bi, v, c, r);
         for (int k = 0; k < NC; k++) begin
            total++; if (vo[k] !== s_vld[k][en]) begin
               bad++; $display("FAIL rand_vld[%0d] edge %0d: got %0b want %0b", k, en, vo[k], s_vld[k][en]);
            end
            total++; if (f_o[k] !== 20'(exp_f(k, en))) begin
               bad++; $display("FAIL rand_f[%0d] edge %0d: got %0d want %0d", k, en, f_o[k], exp_f(k, en));
            end
            total++; if (ov[k] !== exp_o(k, en)) begin
               bad++; $display("FAIL rand_ovf[%0d] edge %0d: got %0b want %0b", k, en, ov[k], exp_o(k, en));
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_gap_max();
      test_saturate();
      test_reset_mid();
      test_clear();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mac_accum.md
# mac_accum

Parametrised multiply-accumulate unit with valid/clear tagging, an optional multiplier pipeline and overflow handling. It is the successor to the single-operand sum-of-squares accumulator in this design. Operands a and b are multiplied per valid sample and summed into f. Each result is flagged with valid_out. An accumulation can be restarted in-band with clear_acc, and overflow either wraps or saturates.

## Interface
- WIDTH_A, 8: width of each unsigned operand a, b.
- WIDTH_F, 20: accumulator/output width; must be ≥ 2*WIDTH_A (elaboration error otherwise).
- PIPE_STAGES, 0: extra register stages after the multiplier, 0..2.
- SATURATE, 1: 1 = clamp on overflow; 0 = wrap modulo 2^WIDTH_F.
- clk  in  1  clock; all state updates on posedge clk.
- reset  in  1  synchronous, active-high reset.
- a  in  WIDTH_A  operand A, unsigned.
- b  in  WIDTH_A  operand B, unsigned; drive b=a for sum of squares.
- valid_in  in  1  sample a, b, clear_acc this edge.
- clear_acc  in  1  qualified by valid_in; this sample starts a new sum.
- f  out  WIDTH_F  accumulated sum.
- valid_out  out  1  f holds a freshly updated sum this cycle.
- overflow  out  1  sticky; set when any accumulation exceeded 2^WIDTH_F−1.

## Operation
- **Reset.** While reset=1 at an edge:
  - f, valid_out, overflow, input registers, pipeline valid/clear tags and product registers all become 0.
  - In-flight samples are discarded.
- **Input stage.**
  - When valid_in=1, a, b and clear_acc are registered.
  - When valid_in=0, the input registers hold their values.
  - clear_acc with valid_in=0 is ignored.
- **Product.**
  - Product p = a_reg*b_reg, 2*WIDTH_A bits unsigned, zero-extended to WIDTH_F+1 for the add.
  - p passes through PIPE_STAGES registers; the valid and clear tags travel alongside it.
- **Accumulate** (at the edge where the tagged valid reaches the final stage):
  - clear tag=1: f ← p; overflow ← 0.
  - clear tag=0: sum = f + p (WIDTH_F+1 bits). If sum[WIDTH_F]=1, overflow ← 1, and:
    - SATURATE=1: f ← all ones.
    - SATURATE=0: f ← sum[WIDTH_F-1:0].
  - Once saturated, f remains all ones until a clear or reset.
  - valid_out is set to 1 at this same edge.
- **Idle.** With no valid sample at the final stage:
  - f and overflow hold.
  - valid_out=0; f is don't-care to consumers but must equal the last sum.
- **No stalls.** No back-pressure exists; one sample per cycle is sustained.

## Timing
- A sample captured at edge k updates f and asserts valid_out at edge k+1+PIPE_STAGES.
  - PIPE_STAGES=0: inputs applied after edge 2 give valid_out=1 with the new f after edge 4.
- valid_out is a pure delayed copy of valid_in; gaps are preserved cycle-for-cycle.
- Back-to-back samples accumulate every cycle.
  - The f feedback loop is single-cycle at the final stage for every PIPE_STAGES value.
- clear on back-to-back samples: the cleared sample's result excludes all earlier samples; the following sample adds onto it.
- reset asserted mid-stream: outputs are 0 after that edge. A sample presented in the same cycle as reset is dropped.
- Reset deasserted: the first valid result can appear no earlier than 2+PIPE_STAGES edges later.

## Structure
- Package mac_pkg holds:
  - default constants WIDTH_A_DEF=8, WIDTH_F_DEF=20, PIPE_STAGES_MAX=2;
  - a typedef struct for the pipeline tag {valid, clear};
  - a function sat_add(f, p, saturate) returning {f_next, ovf}.
- One sub-module, mac_tag_pipe: the parametrised shift register for the valid/clear tags and products, depth PIPE_STAGES+1, synchronous reset.
- Top module mac_accum contains the input registers, the multiplier, the accumulator and the overflow flag.

## Test plan
1. **Basic timing.** Defaults. Reset 1 cycle. a=b=21 valid after edge 2; a=b=36 valid after edge 3; then gap.
   - After edge 4: valid_out=1, f=441.
   - After edge 5: valid_out=1, f=1737.
   - After edge 6: valid_out=0, f=1737.
2. **Gap and max values.** Gap of 2 cycles, then a=b=64, 0, 255, 64 consecutively.
   - Required f: 5833, 5833, 70858, 74954, each with valid_out=1.
3. **Saturate.** SATURATE=1, 17 samples a=b=255.
   - After the 16th result: f=1040400, overflow=0.
   - After the 17th result: f=1048575, overflow=1.
   - An 18th sample keeps f=1048575.
   - Wrap variant, SATURATE=0: the 17th result gives f=56849, overflow=1.
4. **Clear.** After f=441, send a=b=2 with clear_acc=1.
   - Result: f=4, overflow=0.
   - A next sample a=b=3 gives f=13.
   - clear_acc=1 with valid_in=0 has no effect.
5. **Pipeline depth.** PIPE_STAGES=2, repeat scenario 1.
   - Results appear 2 cycles later: f=441 after edge 6, f=1737 after edge 7.
   - Valid gaps are preserved.
6. **Reset mid-stream.** Assert reset at the edge while two samples are in flight.
   - After that edge: f=0, valid_out=0, overflow=0.
   - No valid_out pulse follows for the discarded samples.
